dict_value_decompressor: RTL and testbench



---
 rtl/dict_value_pkg.sv | 28 ++
 rtl/dict_value_decompressor_if.sv | 30 +++
 rtl/dict_value_codebook_lookup.sv | 69 ++++++
 rtl/dict_value_decompressor.sv | 158 +++++++++++++++
 tb/tb_dict_value_decompressor.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dict_value_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dict_value_pkg
//  Description : Shared definitions for the dictionary-value compressor and
//                decompressor: default sizes, FSM state type and the codebook.
//  Revision    : 1.0 - initial release
// ============================================================================
package dict_value_pkg;

    localparam int DEF_CHUNK_SIZE    = 4;
    localparam int DEF_CODEBOOK_SIZE = 8;
    localparam int DEF_INDEX_BITS    = $clog2(DEF_CODEBOOK_SIZE);
    localparam int DEF_NUM_CHUNKS    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } dv_state_t;

    // Entry 0 is the rightmost element of the packed array.
    localparam logic [DEF_CODEBOOK_SIZE-1:0][DEF_CHUNK_SIZE-1:0] CB = {
        4'b1000, 4'b1100, 4'b1110, 4'b1111,
        4'b0111, 4'b0011, 4'b0001, 4'b0000
    };

endpackage
`default_nettype wire

// File: rtl/dict_value_decompressor_if.sv
`default_nettype none
// ============================================================================
//  Module      : dict_value_decompressor_if
//  Description : Input vector handshake and serial output handshake of the
//                dictionary-value decompressor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dict_value_decompressor_if #(
    parameter int NUM_CHUNKS = dict_value_pkg::DEF_NUM_CHUNKS,
    parameter int INDEX_BITS = dict_value_pkg::DEF_INDEX_BITS
);
    logic [NUM_CHUNKS*INDEX_BITS-1:0] compressed_in;
    logic                             in_valid;
    logic                             in_ready;
    logic                             data_out;
    logic                             data_valid;
    logic                             out_ready;
    logic                             decompression_done;

    modport master (
        output compressed_in, in_valid, out_ready,
        input  in_ready, data_out, data_valid, decompression_done
    );

    modport slave (
        input  compressed_in, in_valid, out_ready,
        output in_ready, data_out, data_valid, decompression_done
    );
endinterface
`default_nettype wire

// File: rtl/dict_value_codebook_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : dict_value_codebook_lookup
//  Description : Codebook index -> chunk lookup. Constant ROM by default;
//                a reset-initialised writable register array when
//                DICT_DECOMP_PROG_CB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module dict_value_codebook_lookup
    import dict_value_pkg::*;
#(
    parameter int CHUNK_SIZE    = DEF_CHUNK_SIZE,
    parameter int CODEBOOK_SIZE = DEF_CODEBOOK_SIZE,
    parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE)
) (
`ifdef DICT_DECOMP_PROG_CB_EN
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_we,
    input  wire logic [INDEX_BITS-1:0] i_waddr,
    input  wire logic [CHUNK_SIZE-1:0] i_wdata,
`endif
    input  wire logic [INDEX_BITS-1:0] i_idx,
    output logic      [CHUNK_SIZE-1:0] o_chunk
);

    logic [CHUNK_SIZE-1:0] w_init  [CODEBOOK_SIZE];
    logic [CHUNK_SIZE-1:0] w_table [CODEBOOK_SIZE];

    // Entries beyond the package table are zero.
    generate
        for (genvar e = 0; e < CODEBOOK_SIZE; e++) begin : g_init
            if (e < DEF_CODEBOOK_SIZE) begin : g_pkg
                assign w_init[e] = CHUNK_SIZE'(CB[e]);
            end else begin : g_zero
                assign w_init[e] = '0;
            end
        end
    endgenerate

`ifdef DICT_DECOMP_PROG_CB_EN
    logic [CHUNK_SIZE-1:0] r_cb [CODEBOOK_SIZE];

    // Writable codebook, restored to the package table on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < CODEBOOK_SIZE; e++) begin
                r_cb[e] <= w_init[e];
            end
        end else if (i_we && (32'(i_waddr) < CODEBOOK_SIZE)) begin
            r_cb[i_waddr] <= i_wdata;
        end
    end

    assign w_table = r_cb;
`else
    assign w_table = w_init;
`endif

    // Out-of-range indices decode to an all-zero chunk.
    always_comb begin
        o_chunk = '0;
        if (32'(i_idx) < CODEBOOK_SIZE) begin
            o_chunk = w_table[i_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dict_value_decompressor.sv
`default_nettype none
// ============================================================================
//  Module      : dict_value_decompressor
//  Description : Accepts a packed vector of codebook indices, looks each one
//                up and streams the reconstructed chunks one bit per transfer,
//                MSB first, chunk 0 first. Optional programmable codebook
//                enabled by macro DICT_DECOMP_PROG_CB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module dict_value_decompressor
    import dict_value_pkg::*;
#(
    parameter int CHUNK_SIZE    = DEF_CHUNK_SIZE,
    parameter int CODEBOOK_SIZE = DEF_CODEBOOK_SIZE,
    parameter int INDEX_BITS    = $clog2(CODEBOOK_SIZE),
    parameter int NUM_CHUNKS    = DEF_NUM_CHUNKS
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
`ifdef DICT_DECOMP_PROG_CB_EN
    input  wire logic                  cb_we,
    input  wire logic [INDEX_BITS-1:0] cb_addr,
    input  wire logic [CHUNK_SIZE-1:0] cb_wdata,
`endif
    dict_value_decompressor_if.slave   bus
);

    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int BIT_W = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [BIT_W-1:0] FIRST_BIT  = BIT_W'(CHUNK_SIZE - 1);

    dv_state_t                        r_state;
    dv_state_t                        w_state_nxt;
    logic [NUM_CHUNKS*INDEX_BITS-1:0] r_idx;
    logic [CHUNK_SIZE-1:0]            r_shreg;
    logic [CNT_W-1:0]                 r_chunk_cnt;
    logic [BIT_W-1:0]                 r_bit_cnt;
    logic                             r_data_valid;
    logic                             r_done;

    logic                             w_in_xfer;
    logic                             w_out_xfer;
    logic                             w_chunk_end;
    logic                             w_last_bit;
    logic [CNT_W-1:0]                 w_next_chunk;
    logic [INDEX_BITS-1:0]            w_lookup_idx;
    logic [CHUNK_SIZE-1:0]            w_chunk;

    assign w_in_xfer   = bus.in_valid && (r_state == ST_IDLE);
    assign w_out_xfer  = r_data_valid && bus.out_ready;
    assign w_chunk_end = (r_bit_cnt == '0);
    assign w_last_bit  = w_chunk_end && (r_chunk_cnt == LAST_CHUNK);
    // Saturates on the last chunk; the value is unused there.
    assign w_next_chunk = (r_chunk_cnt == LAST_CHUNK) ? r_chunk_cnt
                                                      : r_chunk_cnt + CNT_W'(1);

    // Single lookup port: chunk 0 of the incoming vector while idle,
    // the following chunk of the latched vector while shifting.
    always_comb begin
        w_lookup_idx = bus.compressed_in[INDEX_BITS-1:0];
        if (r_state == ST_SHIFT) begin
            w_lookup_idx = r_idx[int'(w_next_chunk)*INDEX_BITS +: INDEX_BITS];
        end
    end

`ifdef DICT_DECOMP_PROG_CB_EN
    logic w_cb_we;
    // Codebook writes only land while no stream is in flight.
    assign w_cb_we = cb_we && (r_state == ST_IDLE);
`endif

    dict_value_codebook_lookup #(
        .CHUNK_SIZE    (CHUNK_SIZE),
        .CODEBOOK_SIZE (CODEBOOK_SIZE),
        .INDEX_BITS    (INDEX_BITS)
    ) u_lookup (
`ifdef DICT_DECOMP_PROG_CB_EN
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_cb_we),
        .i_waddr (cb_addr),
        .i_wdata (cb_wdata),
`endif
        .i_idx   (w_lookup_idx),
        .o_chunk (w_chunk)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_in_xfer) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_out_xfer && w_last_bit) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: vector latch, shift register, counters and output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_shreg      <= '0;
            r_chunk_cnt  <= '0;
            r_bit_cnt    <= '0;
            r_data_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        r_idx        <= bus.compressed_in;
                        r_shreg      <= w_chunk;
                        r_chunk_cnt  <= '0;
                        r_bit_cnt    <= FIRST_BIT;
                        r_data_valid <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_out_xfer) begin
                        if (!w_chunk_end) begin
                            r_shreg   <= r_shreg << 1;
                            r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                        end else if (w_last_bit) begin
                            // Clear so data_out idles at zero.
                            r_shreg      <= '0;
                            r_data_valid <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_shreg     <= w_chunk;
                            r_chunk_cnt <= w_next_chunk;
                            r_bit_cnt   <= FIRST_BIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready           = (r_state == ST_IDLE);
    assign bus.data_out           = r_shreg[CHUNK_SIZE-1];
    assign bus.data_valid         = r_data_valid;
    assign bus.decompression_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dict_value_decompressor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dict_value_decompressor
//  Description : Self-checking bench for dict_value_decompressor with a
//                behavioural codebook model and randomized back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dict_value_decompressor;

    localparam int NC = 32;
    localparam int IB = 3;
    localparam int CS = 4;
    localparam int NB = NC * CS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dict_value_decompressor_if #(.NUM_CHUNKS(NC), .INDEX_BITS(IB)) bus();

`ifdef DICT_DECOMP_PROG_CB_EN
    logic          cb_we    = 1'b0;
    logic [IB-1:0] cb_addr  = '0;
    logic [CS-1:0] cb_wdata = '0;
`endif

    dict_value_decompressor #(
        .CHUNK_SIZE    (CS),
        .CODEBOOK_SIZE (8),
        .INDEX_BITS    (IB),
        .NUM_CHUNKS    (NC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DICT_DECOMP_PROG_CB_EN
        .cb_we    (cb_we),
        .cb_addr  (cb_addr),
        .cb_wdata (cb_wdata),
`endif
        .bus      (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [CS-1:0] m_cb [8];
    bit            exp_bits [NB];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decoder: each index selects a codebook entry, emitted MSB first.
    function automatic void model_expand(input logic [NC*IB-1:0] vec);
        int            idx;
        logic [CS-1:0] chunk;
        for (int k = 0; k < NC; k++) begin
            idx   = int'(vec[k*IB +: IB]);
            chunk = (idx < 8) ? m_cb[idx] : '0;
            for (int b = 0; b < CS; b++) begin
                exp_bits[k*CS + b] = chunk[CS-1-b];
            end
        end
    endfunction

    // mode 0: out_ready always 1; 1: alternating 1/0; 2: random.
    // abort_at > 0: assert rst once that many bits have been transferred.
    task automatic run_stream(input string name, input logic [NC*IB-1:0] vec,
                              input int mode, input int abort_at);
        int   pos;
        int   t_last;
        int   w;
        bit   finished;
        bit   prev_stall;
        logic prev_dout;
        model_expand(vec);
        pos = 0; t_last = -1; finished = 0; prev_stall = 0; prev_dout = 1'b0;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check_eq({name, "_ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.compressed_in = vec;
        bus.in_valid      = 1'b1;
        bus.out_ready     = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 700 && !finished; c++) begin
            if (abort_at > 0 && pos == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_eq({name, "_rst_valid"}, 32'(bus.data_valid), 32'd0);
                check_eq({name, "_rst_done"},  32'(bus.decompression_done), 32'd0);
                check_eq({name, "_rst_ready"}, 32'(bus.in_ready), 32'd1);
                check_eq({name, "_rst_dout"},  32'(bus.data_out), 32'd0);
                @(posedge clk); #1;
                check_eq({name, "_rst_done2"}, 32'(bus.decompression_done), 32'd0);
                return;
            end
            check_eq({name, "_valid"}, 32'(bus.data_valid), 32'(pos < NB));
            check_eq({name, "_done"}, 32'(bus.decompression_done),
                     32'(t_last >= 0 && c == t_last + 1));
            check_eq({name, "_in_ready"}, 32'(bus.in_ready),
                     32'(t_last >= 0 && c == t_last + 2));
            if (t_last >= 0 && c == t_last + 2) finished = 1;
            if (bus.data_valid === 1'b1 && prev_stall)
                check_eq({name, "_hold"}, 32'(bus.data_out), 32'(prev_dout));
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (c % 2 == 1);
                default: bus.out_ready = 1'($urandom % 2);
            endcase
            if (bus.data_valid === 1'b1 && bus.out_ready) begin
                if (pos < NB) check_eq({name, "_bit"}, 32'(bus.data_out), 32'(exp_bits[pos]));
                else          check_eq({name, "_extra_bit"}, 32'd1, 32'd0);
                pos++;
                if (pos == NB) t_last = c;
            end
            prev_stall = (bus.data_valid === 1'b1) && !bus.out_ready;
            prev_dout  = bus.data_out;
            if (mode != 0 && pos < NB) begin
                bus.in_valid      = ($urandom % 4 == 0);
                bus.compressed_in = {$urandom, $urandom, $urandom};
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!finished) check_eq({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [NC*IB-1:0] vec;
        logic [CS-1:0]    chunk;
        int               e;
        m_cb = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        bus.compressed_in = '0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset_valid",    32'(bus.data_valid), 32'd0);
        check_eq("reset_dout",     32'(bus.data_out), 32'd0);
        check_eq("reset_done",     32'(bus.decompression_done), 32'd0);

        run_stream("zeros", '0, 0, 0);

        vec = '0;
        for (int k = 0; k < NC; k++) vec[k*IB +: IB] = IB'(k % 8);
        run_stream("ramp", vec, 0, 0);
        run_stream("ramp_alt", vec, 1, 0);

        run_stream("abort", '0, 0, 50);

        vec = '0;
        for (int k = 0; k < NC; k++) vec[k*IB +: IB] = IB'(4);
        run_stream("ones", vec, 0, 0);

        // Round trip: random stream of codebook chunks through a reference
        // compressor (first matching codebook entry) and back.
        for (int r = 0; r < 3; r++) begin
            vec = '0;
            for (int k = 0; k < NC; k++) begin
                chunk = m_cb[$urandom % 8];
                e = 0;
                while (e < 7 && m_cb[e] != chunk) e++;
                vec[k*IB +: IB] = IB'(e);
            end
            run_stream("roundtrip", vec, 2, 0);
        end

`ifdef DICT_DECOMP_PROG_CB_EN
        cb_we = 1'b1; cb_addr = '0; cb_wdata = 4'b1010;
        @(posedge clk); #1;
        cb_we = 1'b0;
        m_cb[0] = 4'b1010;
        run_stream("prog_cb", '0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
